// File: rtl/led_share_pkg.sv
// Shared types, constants and round-robin helper for the LED sharing sequencer.
package led_share_pkg;

    localparam int PAT_W    = 8;
    localparam int IDX_W    = $clog2(PAT_W);
    localparam int NREQ_DEF = 4;
    localparam int MAX_REQ  = 8;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_sel_t;

    // First set request strictly after ptr, wrapping modulo n.
    function automatic rr_sel_t rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        rr_sel_t sel;
        int      c;
        sel = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= n) begin
                c = (int'(ptr) + i) % n;
                if (req[c[2:0]]) begin
                    sel.found = 1'b1;
                    sel.idx   = c[2:0];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/led_share_sequencer_if.sv
// Requester-side bundle of the LED sharing sequencer.
interface led_share_sequencer_if
    import led_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);

    logic [NREQ-1:0]       req;
    logic [NREQ*PAT_W-1:0] pattern;
    logic [NREQ-1:0]       grant;
    logic                  LED;
    logic                  busy;

    modport master (
        output req,
        output pattern,
        input  grant,
        input  LED,
        input  busy
    );

    modport slave (
        input  req,
        input  pattern,
        output grant,
        output LED,
        output busy
    );

endinterface

// File: rtl/led_tick_gen.sv
// Free-running prescaler; one-cycle registered tick after the counter hits all-ones.
module led_tick_gen #(
    parameter int PRESCALE_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + PRESCALE_W'(1);
            r_tick <= &r_cnt;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_share_sequencer.sv
// Round-robin owner of the board LED; shifts the owner's 8-bit pattern out per tick.
module led_share_sequencer
    import led_share_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int PRESCALE_W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_share_sequencer_if.slave  bus
);

    logic               w_tick;
    logic [MAX_REQ-1:0] w_req8;
    rr_sel_t            w_win;
    logic [PAT_W-1:0]   w_pat;
    logic [NREQ-1:0]    w_onehot;
    logic               w_rearb;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [2:0]         r_ptr;
    logic [PAT_W-1:0]   r_shadow;
    logic [NREQ-1:0]    r_grant;
    logic               r_led;
    logic               r_busy;

    led_tick_gen #(
        .PRESCALE_W(PRESCALE_W)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (w_tick)
    );

    always_comb begin
        w_req8             = '0;
        w_req8[NREQ-1:0]   = bus.req;
        w_win              = rr_next(w_req8, r_ptr, NREQ);
        w_pat              = '0;
        w_onehot           = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win.idx == 3'(i)) begin
                w_pat       = bus.pattern[i*PAT_W +: PAT_W];
                w_onehot[i] = 1'b1;
            end
        end
        // Owner drop and end of pattern both fall back to a fresh arbitration.
        w_rearb = (r_state == IDLE)
               || !(|(bus.req & r_grant))
               || (r_idx == IDX_W'(PAT_W-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_ptr    <= 3'(NREQ-1);
            r_shadow <= '0;
            r_grant  <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_tick) begin
            if (w_rearb) begin
                if (w_win.found) begin
                    r_state  <= SHOW;
                    r_grant  <= w_onehot;
                    r_shadow <= w_pat;
                    r_idx    <= '0;
                    r_led    <= w_pat[0];
                    r_busy   <= 1'b1;
                    r_ptr    <= w_win.idx;
                end else begin
                    r_state  <= IDLE;
                    r_grant  <= '0;
                    r_idx    <= '0;
                    r_led    <= 1'b0;
                    r_busy   <= 1'b0;
                end
            end else begin
                r_idx <= r_idx + IDX_W'(1);
                r_led <= r_shadow[r_idx + IDX_W'(1)];
            end
        end
    end

    assign bus.grant = r_grant;
    assign bus.LED   = r_led;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_led_share_sequencer.sv
// Directed bench for led_share_sequencer with a 4-cycle tick and four requesters.
module tb_led_share_sequencer;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    led_share_sequencer_if #(.NREQ(4)) bus ();

    led_share_sequencer #(
        .NREQ      (4),
        .PRESCALE_W(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_pat(input int i, input logic [7:0] p);
        bus.pattern[i*8 +: 8] = p;
    endtask

    // Advance n sequencer updates; ends on a falling edge.
    task automatic next_upd(input int n);
        repeat (4*n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, release, then stop just after the first tick update.
    task automatic do_reset(input logic [3:0] rq);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = rq;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_tick_grant", 32'(bus.grant), 32'(4'b0000));
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] exp_g;
    logic [7:0] pv;
    logic [7:0] pv2;

    initial begin
        n_chk       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.req     = 4'b1111;
        bus.pattern = {4{8'hFF}};

        // Reset state with all requests pending
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 32'(4'b0000));
        chk("rst_led",   32'(bus.LED),   32'(1'b0));
        chk("rst_busy",  32'(bus.busy),  32'(1'b0));

        // Round-robin, all patterns FF
        do_reset(4'b1111);
        exp_g = 4'b0001;
        chk("rr_first", 32'(bus.grant), 32'(exp_g));
        chk("rr_led",   32'(bus.LED),   32'(1'b1));
        for (int p = 0; p < 4; p++) begin
            next_upd(7);
            chk("rr_hold", 32'(bus.grant), 32'(exp_g));
            chk("rr_led",  32'(bus.LED),   32'(1'b1));
            next_upd(1);
            exp_g = {exp_g[2:0], exp_g[3]};
            chk("rr_next", 32'(bus.grant), 32'(exp_g));
            chk("rr_busy", 32'(bus.busy),  32'(1'b1));
        end

        // Single requester, back-to-back passes
        bus.pattern = '0;
        pv = 8'b1010_0101;
        set_pat(2, pv);
        do_reset(4'b0100);
        for (int b = 0; b < 8; b++) begin
            chk("single_led",   32'(bus.LED),   32'(pv[b]));
            chk("single_grant", 32'(bus.grant), 32'(4'b0100));
            next_upd(1);
        end
        chk("single_again_led",  32'(bus.LED),   32'(pv[0]));
        chk("single_again_grant", 32'(bus.grant), 32'(4'b0100));
        chk("single_again_busy", 32'(bus.busy),  32'(1'b1));

        // Abort: owner 1 drops with requester 3 pending
        bus.pattern = '0;
        set_pat(1, 8'hFF);
        set_pat(3, 8'h02);
        do_reset(4'b0010);
        chk("abort_own", 32'(bus.grant), 32'(4'b0010));
        bus.req = 4'b1010;
        next_upd(2);
        chk("abort_keep", 32'(bus.grant), 32'(4'b0010));
        bus.req = 4'b1000;
        next_upd(1);
        chk("abort_grant", 32'(bus.grant), 32'(4'b1000));
        chk("abort_led0",  32'(bus.LED),   32'(1'b0));
        chk("abort_busy",  32'(bus.busy),  32'(1'b1));
        next_upd(1);
        chk("abort_led1",  32'(bus.LED),   32'(1'b1));
        bus.req = 4'b0000;
        next_upd(1);
        chk("drop_grant", 32'(bus.grant), 32'(4'b0000));
        chk("drop_led",   32'(bus.LED),   32'(1'b0));
        chk("drop_busy",  32'(bus.busy),  32'(1'b0));
        next_upd(1);
        chk("idle_grant", 32'(bus.grant), 32'(4'b0000));

        // Pattern change mid-pass takes effect on the next snapshot
        bus.pattern = '0;
        pv  = 8'h0F;
        pv2 = 8'hF0;
        set_pat(0, pv);
        do_reset(4'b0001);
        chk("mid_b0", 32'(bus.LED), 32'(pv[0]));
        next_upd(1);
        chk("mid_b1", 32'(bus.LED), 32'(pv[1]));
        set_pat(0, pv2);
        for (int b = 2; b < 8; b++) begin
            next_upd(1);
            chk("mid_old", 32'(bus.LED), 32'(pv[b]));
        end
        for (int b = 0; b < 8; b++) begin
            next_upd(1);
            chk("mid_new", 32'(bus.LED), 32'(pv2[b]));
        end

        // Async reset mid-pattern; pointer must restart at requester 0
        bus.pattern = {4{8'hFF}};
        do_reset(4'b0101);
        chk("ar_own", 32'(bus.grant), 32'(4'b0001));
        next_upd(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(bus.grant), 32'(4'b0000));
        chk("ar_led",   32'(bus.LED),   32'(1'b0));
        chk("ar_busy",  32'(bus.busy),  32'(1'b0));
        @(negedge clk);
        bus.req = 4'b0011;
        rst_n   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ar_pre", 32'(bus.grant), 32'(4'b0000));
        @(posedge clk);
        @(negedge clk);
        chk("ar_restart", 32'(bus.grant), 32'(4'b0001));
        chk("ar_led_on",  32'(bus.LED),   32'(1'b1));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/led_share_sequencer.md
Name: led_share_sequencer

Overview:
- Shares the single board LED between NREQ requesters.
- Each requester supplies an 8-bit blink pattern; a round-robin arbiter grants the LED to one requester at a time.
- The granted pattern is shifted out one bit per prescaler tick.
- Sits between status sources (PCI activity, error flags, heartbeat) and the LED pin, replacing free-running counter blinkers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PRESCALE_W, 20, prescaler width; one tick every 2^PRESCALE_W clk cycles.
- PAT_W, 8, pattern length in ticks; fixed at 8 by the package.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester LED request, level-sensitive.
- pattern  input  NREQ*PAT_W  requester i pattern at bits [i*PAT_W +: PAT_W]; bit 0 is shown first.
- grant  output  NREQ  one-hot current owner; all-zero when idle.
- LED  output  1  LED drive, active-high.
- busy  output  1  high while a pattern is being shown.

Behaviour:
- Reset: asynchronous, active-low (rst_n=0), single clock clk. While rst_n=0 and after release, the following hold until the first tick:
  - prescaler=0, grant=0, LED=0, busy=0.
  - state=IDLE, bit index=0, round-robin pointer=NREQ-1, so requester 0 has first priority.
- Prescaler (led_tick_gen): free-running PRESCALE_W-bit up-counter, wraps naturally. tick is a 1-cycle registered pulse, high in the cycle after the counter reaches all-ones. First tick is at cycle 2^PRESCALE_W after reset release.
- All state changes occur only in a cycle where tick=1. Outputs are registered and update the cycle after that tick edge.
- IDLE:
  - On tick with req!=0: select the first set req bit strictly after the pointer, modulo NREQ.
  - Set grant to that one-hot, snapshot its pattern into a shadow register, set idx=0, LED=shadow[0], busy=1, pointer=winner. Go to SHOW.
  - On tick with req=0: stay in IDLE, outputs unchanged.
- SHOW, on each tick, evaluated in this priority order:
  - (a) If the owner's req=0: abort. grant=0, LED=0, busy=0. Re-arbitrate in the same tick per the IDLE rule, excluding the dropped requester's bit (it is 0 anyway). If no req, go to IDLE.
  - (b) Else if idx<PAT_W-1: idx+=1, LED=shadow[idx+1].
  - (c) Else (pattern complete): re-arbitrate exactly as in IDLE.
    - The same requester wins again only if no other req is set.
    - The winner's pattern is re-snapshotted, so back-to-back passes have no LED gap.
    - If req=0, go to IDLE with LED=0, grant=0, busy=0.
- Pattern changes while shown are ignored until the next snapshot.
- Requests raised or dropped between ticks have no effect unless still present at a tick.
- Simultaneous events at one tick: a new request arriving while the owner drops its request is resolved by rule (a), then arbitration, in that same tick.
- Pattern 0x00 is legal: the LED stays off, but the grant is still held for PAT_W ticks.
- Reset mid-pattern: immediate return to reset values; no partial state retained.
- Invariants: grant is one-hot or zero; busy == |grant; LED=0 whenever busy=0.

Decomposition:
- Package led_share_pkg holds:
  - PAT_W=8 and the NREQ default.
  - State enum {IDLE, SHOW}.
  - Round-robin next-owner function (mask above pointer, find-first-set, wrap).
- Sub-module led_tick_gen (params PRESCALE_W; ports clk, rst_n, tick) holds the prescaler.
- All other logic (state, idx, shadow, pointer, grant, LED) stays in led_share_sequencer.

Test Plan:
- Bench uses PRESCALE_W=2 (tick every 4 cycles) and NREQ=4.
- Reset: hold rst_n=0 with req=4'b1111 -> grant=0, LED=0, busy=0. After release, first grant=4'b0001 appears 1 cycle after the first tick (cycle 4).
- Single requester: req=4'b0100, pattern2=8'b1010_0101 -> over 8 ticks LED = 1,0,1,0,0,1,0,1. grant stays 4'b0100 and the next pass follows with no gap.
- Round-robin: req=4'b1111, all patterns 8'hFF -> grant sequence 0001,0010,0100,1000,0001, each held exactly 8 ticks (32 cycles); LED=1 throughout.
- Abort: owner 1 drops req after 3 ticks while req3=1 -> at the next tick grant=4'b1000 with idx=0. With no other req, grant=0 and LED=0 instead.
- Mid-pattern change: alter pattern0 from 8'h0F to 8'hF0 at tick 2 -> the current pass still shows 8'h0F; the next pass shows 8'hF0.
- Async reset mid-SHOW: assert rst_n=0 between clk edges -> LED, grant and busy go to 0 immediately. After release, arbitration restarts from requester 0.
